// File: rtl/xilly_multi_reset_if.sv
// Channel bundle between the Xillybus core's open lines and the per-stream reset generator.
interface xilly_multi_reset_if #(
    parameter int unsigned NCH = 4
);
    logic [NCH-1:0] xil_open;
    logic [NCH-1:0] reset_out;
    logic [NCH-1:0] reset_done;
    logic           reset_any;

    modport master (
        output xil_open,
        input  reset_out,
        input  reset_done,
        input  reset_any
    );

    modport slave (
        input  xil_open,
        output reset_out,
        output reset_done,
        output reset_any
    );
endinterface

// File: rtl/xilly_multi_reset.sv
// Per-channel stretched, retriggerable reset pulse generator driven by Xillybus open lines.
// Optional hold-while-closed behaviour: define XILLY_MULTI_RESET_HOLD_EN.
module xilly_multi_reset #(
    parameter int unsigned NCH  = 4,
    parameter int unsigned LEN  = 16,
    parameter int unsigned MODE = 0
) (
    input  logic               clk,
    input  logic               rst,
    xilly_multi_reset_if.slave bus
);
    localparam int unsigned   CW       = $clog2(LEN + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LEN - 1);

    if (NCH == 0 || NCH > 32) begin : g_bad_nch
        $error("xilly_multi_reset: NCH must be 1..32");
    end
    if (LEN == 0 || LEN > 65535) begin : g_bad_len
        $error("xilly_multi_reset: LEN must be 1..65535");
    end
    if (MODE > 2) begin : g_bad_mode
        $error("xilly_multi_reset: MODE must be 0, 1 or 2");
    end

    logic [NCH-1:0] r_open_q;
    logic [NCH-1:0] r_active;
    logic [NCH-1:0] r_done;
    logic [CW-1:0]  r_cnt [NCH];

    logic [NCH-1:0] w_trig;
    logic [NCH-1:0] w_active_next;
    logic [CW-1:0]  w_cnt_next [NCH];

    // Trigger edge selection; "both" is simply any change of level.
    if (MODE == 0) begin : g_trig_fall
        assign w_trig = r_open_q & ~bus.xil_open;
    end else if (MODE == 1) begin : g_trig_rise
        assign w_trig = ~r_open_q & bus.xil_open;
    end else begin : g_trig_both
        assign w_trig = r_open_q ^ bus.xil_open;
    end

    // Next-state per channel; a trigger always wins over expiry so retriggers never drop the pulse.
    always_comb begin
        w_active_next = r_active;
        for (int i = 0; i < int'(NCH); i++) begin
            w_cnt_next[i] = r_cnt[i];
            if (w_trig[i]) begin
                w_active_next[i] = 1'b1;
                w_cnt_next[i]    = CNT_LOAD;
            end else if (r_active[i] && (r_cnt[i] != '0)) begin
                w_cnt_next[i] = r_cnt[i] - CW'(1);
            end else if (r_active[i]) begin
`ifdef XILLY_MULTI_RESET_HOLD_EN
                w_active_next[i] = ~r_open_q[i];
`else
                w_active_next[i] = 1'b0;
`endif
            end
        end
    end

    // Reset state is "pulse in progress" so every channel emits a power-on pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_open_q <= '0;
            r_active <= '1;
            r_done   <= '0;
            for (int i = 0; i < int'(NCH); i++) begin
                r_cnt[i] <= CNT_LOAD;
            end
        end else begin
            r_open_q <= bus.xil_open;
            r_active <= w_active_next;
            r_done   <= r_active & ~w_active_next;
            for (int i = 0; i < int'(NCH); i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

    assign bus.reset_out  = r_active;
    assign bus.reset_done = r_done;
    assign bus.reset_any  = |r_active;

endmodule

// File: tb/tb_xilly_multi_reset.sv
// Self-checking bench for xilly_multi_reset: three instances (close/LEN16, close/LEN1, both/LEN16).
module tb_xilly_multi_reset;
    localparam int unsigned NCH = 4;

    typedef struct packed {
        logic [NCH-1:0] out;
        logic [NCH-1:0] done;
        logic           any;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    xilly_multi_reset_if #(.NCH(NCH)) bus0 ();
    xilly_multi_reset_if #(.NCH(NCH)) bus1 ();
    xilly_multi_reset_if #(.NCH(NCH)) bus2 ();

    xilly_multi_reset #(.NCH(NCH), .LEN(16), .MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    xilly_multi_reset #(.NCH(NCH), .LEN(1),  .MODE(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    xilly_multi_reset #(.NCH(NCH), .LEN(16), .MODE(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [NCH-1:0] o, input logic [NCH-1:0] d);
        exp_t e;
        e.out  = o;
        e.done = d;
        e.any  = |o;
        return e;
    endfunction

    function automatic exp_t obs(input int which);
        exp_t g;
        if (which == 0)      g = {bus0.reset_out, bus0.reset_done, bus0.reset_any};
        else if (which == 1) g = {bus1.reset_out, bus1.reset_done, bus1.reset_any};
        else                 g = {bus2.reset_out, bus2.reset_done, bus2.reset_any};
        return g;
    endfunction

    // Power-on: outputs forced during rst, then a LEN-cycle pulse and one reset_done.
    task automatic test_reset();
        exp_t e, g;
        bus0.xil_open = '0;
        bus1.xil_open = '0;
        bus2.xil_open = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            g = obs(0);
            n_tests++;
            if (g !== mk(4'hF, 4'h0)) begin
                n_fail++;
                $display("FAIL reset_held c=%0d got=%h exp=%h", c, g, mk(4'hF, 4'h0));
            end
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        g = obs(1);
        n_tests++;
        if (g !== mk(4'hF, 4'h0)) begin
            n_fail++;
            $display("FAIL reset_release_len1 got=%h exp=%h", g, mk(4'hF, 4'h0));
        end
        for (int j = 1; j <= 19; j++) begin
`ifdef XILLY_MULTI_RESET_HOLD_EN
            q0.push_back(mk(4'hF, 4'h0));
            q1.push_back(mk(4'hF, 4'h0));
`else
            q0.push_back(j <= 15 ? mk(4'hF, 4'h0) : (j == 16 ? mk(4'h0, 4'hF) : mk(4'h0, 4'h0)));
            q1.push_back(j == 1 ? mk(4'h0, 4'hF) : mk(4'h0, 4'h0));
`endif
        end
        for (int j = 1; q0.size() != 0; j++) begin
            @(negedge clk);
            e = q0.pop_front();
            g = obs(0);
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL power_on_len16 j=%0d got=%h exp=%h", j, g, e);
            end
            e = q1.pop_front();
            g = obs(1);
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL power_on_len1 j=%0d got=%h exp=%h", j, g, e);
            end
        end
    endtask

    // Open every channel and let all pulses drain.
    task automatic test_idle();
        exp_t g;
        bus0.xil_open = '1;
        bus1.xil_open = '1;
        bus2.xil_open = '1;
        repeat (40) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            g = obs(d);
            n_tests++;
            if (g !== mk(4'h0, 4'h0)) begin
                n_fail++;
                $display("FAIL idle dut%0d got=%h exp=%h", d, g, mk(4'h0, 4'h0));
            end
        end
    endtask

    // MODE 0 close on ch2; reopen later (extends the pulse only with hold enabled).
    task automatic test_close();
        exp_t e, g;
        int endj;
`ifdef XILLY_MULTI_RESET_HOLD_EN
        endj = 31;
`else
        endj = 16;
`endif
        bus0.xil_open = 4'b1011;
        for (int j = 1; j <= 36; j++)
            q0.push_back(j <= endj ? mk(4'b0100, 4'h0) : (j == endj + 1 ? mk(4'h0, 4'b0100) : mk(4'h0, 4'h0)));
        for (int j = 1; q0.size() != 0; j++) begin
            @(negedge clk);
            e = q0.pop_front();
            g = obs(0);
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL close_ch2 j=%0d got=%h exp=%h", j, g, e);
            end
            if (j == 30) bus0.xil_open = '1;
        end
    endtask

    // MODE 2: fall then rise 8 cycles later merges into one pulse with a single reset_done.
    task automatic test_retrigger();
        exp_t e, g;
        bus2.xil_open = 4'b1110;
        for (int j = 1; j <= 30; j++)
            q2.push_back(j <= 24 ? mk(4'b0001, 4'h0) : (j == 25 ? mk(4'h0, 4'b0001) : mk(4'h0, 4'h0)));
        for (int j = 1; q2.size() != 0; j++) begin
            @(negedge clk);
            e = q2.pop_front();
            g = obs(2);
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL retrigger_ch0 j=%0d got=%h exp=%h", j, g, e);
            end
            if (j == 8) bus2.xil_open = '1;
        end
    endtask

    // Second close lands exactly on the cnt==0 cycle: trigger wins, no reset_done gap.
    task automatic test_trig_at_zero();
        exp_t e, g;
        int endj;
`ifdef XILLY_MULTI_RESET_HOLD_EN
        endj = 41;
`else
        endj = 32;
`endif
        bus0.xil_open = 4'b1101;
        for (int j = 1; j <= 46; j++)
            q0.push_back(j <= endj ? mk(4'b0010, 4'h0) : (j == endj + 1 ? mk(4'h0, 4'b0010) : mk(4'h0, 4'h0)));
        for (int j = 1; q0.size() != 0; j++) begin
            @(negedge clk);
            e = q0.pop_front();
            g = obs(0);
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL trig_at_zero j=%0d got=%h exp=%h", j, g, e);
            end
            if (j == 10 || j == 40) bus0.xil_open = '1;
            if (j == 16)            bus0.xil_open = 4'b1101;
        end
    endtask

    // LEN=1: ch1 and ch3 close together.
    task automatic test_simultaneous();
        exp_t e, g;
        int endj;
`ifdef XILLY_MULTI_RESET_HOLD_EN
        endj = 6;
`else
        endj = 1;
`endif
        bus1.xil_open = 4'b0101;
        for (int j = 1; j <= 10; j++)
            q1.push_back(j <= endj ? mk(4'b1010, 4'h0) : (j == endj + 1 ? mk(4'h0, 4'b1010) : mk(4'h0, 4'h0)));
        for (int j = 1; q1.size() != 0; j++) begin
            @(negedge clk);
            e = q1.pop_front();
            g = obs(1);
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL simultaneous j=%0d got=%h exp=%h", j, g, e);
            end
            if (j == 5) bus1.xil_open = '1;
        end
    endtask

    // rst mid-pulse: immediate reset values, then a fresh power-on pulse (merged with an open edge on MODE 2).
    task automatic test_async_reset();
        exp_t e, g;
        bus0.xil_open = 4'b1011;
        for (int j = 1; j <= 4; j++) q0.push_back(mk(4'b0100, 4'h0));
        for (int j = 1; q0.size() != 0; j++) begin
            @(negedge clk);
            e = q0.pop_front();
            g = obs(0);
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL pre_reset_pulse j=%0d got=%h exp=%h", j, g, e);
            end
        end
        #2;
        rst = 1'b1;
        bus0.xil_open = '1;
        #1;
        for (int d = 0; d < 3; d += 2) begin
            g = obs(d);
            n_tests++;
            if (g !== mk(4'hF, 4'h0)) begin
                n_fail++;
                $display("FAIL async_reset dut%0d got=%h exp=%h", d, g, mk(4'hF, 4'h0));
            end
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            q0.push_back(j <= 15 ? mk(4'hF, 4'h0) : (j == 16 ? mk(4'h0, 4'hF) : mk(4'h0, 4'h0)));
            q2.push_back(j <= 16 ? mk(4'hF, 4'h0) : (j == 17 ? mk(4'h0, 4'hF) : mk(4'h0, 4'h0)));
        end
        for (int j = 1; q0.size() != 0; j++) begin
            @(negedge clk);
            e = q0.pop_front();
            g = obs(0);
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL post_reset_len16 j=%0d got=%h exp=%h", j, g, e);
            end
            e = q2.pop_front();
            g = obs(2);
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL post_reset_mode2 j=%0d got=%h exp=%h", j, g, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_close();
        test_retrigger();
        test_trig_at_zero();
        test_simultaneous();
        test_idle();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
